gate_logic_pipe: RTL and testbench

Parametrised, registered successor to the team's fixed 4-bit gate block. It applies one of eight bitwise gate functions, selected per transaction, to WIDTH-bit operand vectors. Results are carried in a one-deep output register with a valid/ready handshake, together with reduction flags and a saturating transaction counter. It sits between operand sources and downstream datapath consumers that need back-pressure.

---
 rtl/gate_pkg.sv | 26 ++
 rtl/gate_op_core.sv | 33 +++
 rtl/gate_logic_pipe.sv | 99 +++++++++
 tb/tb_gate_logic_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared opcode definitions for the gate-function datapath blocks.
package gate_pkg;

    localparam int GATE_OP_W = 3;

    typedef enum logic [GATE_OP_W-1:0] {
        GATE_AND   = 3'd0,
        GATE_OR    = 3'd1,
        GATE_XOR   = 3'd2,
        GATE_XNOR  = 3'd3,
        GATE_NAND  = 3'd4,
        GATE_NOR   = 3'd5,
        GATE_ANDOR = 3'd6,
        GATE_NOT   = 3'd7
    } gate_op_e;

    // Registered status bits that travel alongside each result.
    typedef struct packed {
        logic zero;
        logic ones;
        logic par;
    } gate_flags_t;

    localparam gate_flags_t GATE_FLAGS_RST = '{zero: 1'b1, ones: 1'b0, par: 1'b0};

endpackage

// File: rtl/gate_op_core.sv
// Combinational bitwise gate evaluator; one lane of WIDTH bits, reusable per lane.
module gate_op_core
    import gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [GATE_OP_W-1:0] op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [WIDTH-1:0]     c_i,
    input  logic [WIDTH-1:0]     d_i,
    output logic [WIDTH-1:0]     res_o
);

    gate_op_e op;
    assign op = gate_op_e'(op_i);

    always_comb begin
        res_o = '0;
        case (op)
            GATE_AND:   res_o = a_i & b_i;
            GATE_OR:    res_o = a_i | b_i;
            GATE_XOR:   res_o = a_i ^ b_i;
            GATE_XNOR:  res_o = a_i ~^ b_i;
            GATE_NAND:  res_o = ~(a_i & b_i);
            GATE_NOR:   res_o = ~(a_i | b_i);
            GATE_ANDOR: res_o = (a_i & b_i) | (c_i & d_i);
            GATE_NOT:   res_o = ~a_i;
            default:    res_o = '0;
        endcase
    end

endmodule

// File: rtl/gate_logic_pipe.sv
// Registered gate block: one-deep output stage with valid/ready, reduction flags
// and a saturating count of accepted transactions.
module gate_logic_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GATE_OP_W-1:0] op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 flag_zero,
    output logic                 flag_ones,
    output logic                 flag_par,
    output logic [CNT_W-1:0]     txn_count
);

    if (WIDTH < 1) begin : g_bad_width
        $error("gate_logic_pipe: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("gate_logic_pipe: CNT_W must be >= 1");
    end

    logic [WIDTH-1:0] core_res;
    gate_flags_t      core_flags;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q,   res_d;
    gate_flags_t      flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             accept;

    gate_op_core #(.WIDTH(WIDTH)) u_core (
        .op_i  (op),
        .a_i   (a),
        .b_i   (b),
        .c_i   (c),
        .d_i   (d),
        .res_o (core_res)
    );

    // Flags are derived before the register so they stay aligned with result.
    assign core_flags.zero = ~|core_res;
    assign core_flags.ones = &core_res;
    assign core_flags.par  = ^core_res;

    // The slot is free when empty or when its occupant leaves this edge.
    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            res_d   = core_res;
            flags_d = core_flags;
            if (~&cnt_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= GATE_FLAGS_RST;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign flag_zero = flags_q.zero;
    assign flag_ones = flags_q.ones;
    assign flag_par  = flags_q.par;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_gate_logic_pipe.sv
// Directed + random bench driving four gate_logic_pipe configurations in lockstep
// (W4/C16, W4/C2, W1, W32) against a scoreboard of expected results.
module tb_gate_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] op = 3'd0;

    logic [3:0]  a4 = '0, b4 = '0, c4 = '0, d4 = '0;
    logic [0:0]  a1 = '0, b1 = '0, c1 = '0, d1 = '0;
    logic [31:0] a32 = '0, b32 = '0, c32 = '0, d32 = '0;

    logic        irdy4, ov4, fz4, fo4, fp4;
    logic [3:0]  res4;
    logic [15:0] cnt4;
    logic        irdys, ovs, fzs, fos, fps;
    logic [3:0]  ress;
    logic [1:0]  cnts;
    logic        irdy1, ov1, fz1, fo1, fp1;
    logic [0:0]  res1;
    logic [15:0] cnt1;
    logic        irdy32, ov32, fz32, fo32, fp32;
    logic [31:0] res32;
    logic [15:0] cnt32;

    gate_logic_pipe #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy4), .op(op),
        .a(a4), .b(b4), .c(c4), .d(d4), .out_valid(ov4), .out_ready(out_ready),
        .result(res4), .flag_zero(fz4), .flag_ones(fo4), .flag_par(fp4), .txn_count(cnt4));

    gate_logic_pipe #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdys), .op(op),
        .a(a4), .b(b4), .c(c4), .d(d4), .out_valid(ovs), .out_ready(out_ready),
        .result(ress), .flag_zero(fzs), .flag_ones(fos), .flag_par(fps), .txn_count(cnts));

    gate_logic_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy1), .op(op),
        .a(a1), .b(b1), .c(c1), .d(d1), .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .flag_zero(fz1), .flag_ones(fo1), .flag_par(fp1), .txn_count(cnt1));

    gate_logic_pipe #(.WIDTH(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy32), .op(op),
        .a(a32), .b(b32), .c(c32), .d(d32), .out_valid(ov32), .out_ready(out_ready),
        .result(res32), .flag_zero(fz32), .flag_ones(fo32), .flag_par(fp32), .txn_count(cnt32));

    typedef struct {
        logic [3:0]  r4;
        logic        r1;
        logic [31:0] r32;
    } exp_t;

    exp_t q[$];
    int   cnt = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] gref(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z,
                                         input logic [31:0] w);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x ^ y);
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return (x & y) | (z & w);
            default: return ~x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        logic vexp;
        int   csat;
        exp_t e;
        vexp = (q.size() != 0);
        csat = (cnt > 3) ? 3 : cnt;
        chk("valid4", {31'b0, ov4}, {31'b0, vexp});
        chk("valid_sat", {31'b0, ovs}, {31'b0, vexp});
        chk("valid1", {31'b0, ov1}, {31'b0, vexp});
        chk("valid32", {31'b0, ov32}, {31'b0, vexp});
        chk("cnt4", {16'b0, cnt4}, cnt);
        chk("cnt_sat", {30'b0, cnts}, csat);
        chk("cnt32", {16'b0, cnt32}, cnt);
        if (vexp) begin
            e = q[0];
            chk("res4", {28'b0, res4}, {28'b0, e.r4});
            chk("zero4", {31'b0, fz4}, {31'b0, e.r4 == 4'h0});
            chk("ones4", {31'b0, fo4}, {31'b0, e.r4 == 4'hF});
            chk("par4", {31'b0, fp4}, {31'b0, ^e.r4});
            chk("res_sat", {28'b0, ress}, {28'b0, e.r4});
            chk("res1", {31'b0, res1}, {31'b0, e.r1});
            chk("flags1", {29'b0, fz1, fo1, fp1}, {29'b0, ~e.r1, e.r1, e.r1});
            chk("res32", res32, e.r32);
            chk("flags32", {29'b0, fz32, fo32, fp32},
                {29'b0, e.r32 == 32'h0, e.r32 == 32'hFFFF_FFFF, ^e.r32});
        end
    endtask

    // One clock of traffic: drive, check in_ready, update the model, then check outputs.
    task automatic xfer(input logic v, input logic [2:0] o, input logic ordy,
                        input logic use_tab, input logic [3:0] tab);
        exp_t        e;
        logic [31:0] t;
        logic        irdy;
        in_valid  = v;
        op        = o;
        out_ready = ordy;
        #1;
        irdy = (q.size() == 0) || ordy;
        chk("in_ready4", {31'b0, irdy4}, {31'b0, irdy});
        chk("in_ready32", {31'b0, irdy32}, {31'b0, irdy});
        t     = gref(o, {28'b0, a4}, {28'b0, b4}, {28'b0, c4}, {28'b0, d4});
        e.r4  = use_tab ? tab : t[3:0];
        t     = gref(o, {31'b0, a1}, {31'b0, b1}, {31'b0, c1}, {31'b0, d1});
        e.r1  = t[0];
        e.r32 = gref(o, a32, b32, c32, d32);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (v && irdy) begin
            q.push_back(e);
            cnt++;
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input logic ordy);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = ordy;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        cnt = 0;
        chk("rst_valid", {28'b0, ov4, ovs, ov1, ov32}, 32'h0);
        chk("rst_res4", {28'b0, res4}, 32'h0);
        chk("rst_res1", {31'b0, res1}, 32'h0);
        chk("rst_res32", res32, 32'h0);
        chk("rst_zero", {28'b0, fz4, fzs, fz1, fz32}, 32'hF);
        chk("rst_ones", {28'b0, fo4, fos, fo1, fo32}, 32'h0);
        chk("rst_par", {28'b0, fp4, fps, fp1, fp32}, 32'h0);
        chk("rst_cnt", {16'b0, cnt4}, 32'h0);
        chk("rst_cnt_sat", {30'b0, cnts}, 32'h0);
        chk("rst_in_ready", {28'b0, irdy4, irdys, irdy1, irdy32}, 32'hF);
    endtask

    logic [3:0] sweep_tab [8];

    initial begin
        sweep_tab = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0001, 4'b1010, 4'b0011};

        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Opcode sweep, back-to-back
        a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b0011; d4 = 4'b0110;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b1;
        a32 = 32'hF0F0_F0F0; b32 = 32'hFF00_FF00; c32 = 32'h0FF0_0FF0; d32 = 32'h3C3C_3C3C;
        for (int i = 0; i < 8; i++) xfer(1'b1, 3'(i), 1'b1, 1'b1, sweep_tab[i]);
        xfer(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);

        // Flags
        a4 = '0; b4 = '0; c4 = '0; d4 = '0;
        a1 = '0; b1 = '0; c1 = '0; d1 = '0;
        a32 = '0; b32 = '0; c32 = '0; d32 = '0;
        xfer(1'b1, 3'd6, 1'b1, 1'b1, 4'b0000);
        xfer(1'b1, 3'd7, 1'b1, 1'b1, 4'b1111);
        a4 = 4'b0001; b4 = 4'b0001; a1 = 1'b1; b1 = 1'b1; a32 = 32'h1; b32 = 32'h1;
        xfer(1'b1, 3'd0, 1'b1, 1'b1, 4'b0001);
        xfer(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
        xfer(1'b0, 3'd0, 1'b0, 1'b0, 4'h0);

        // Back-pressure: stall three cycles with new operands offered, then swap
        do_reset(1'b1);
        a4 = 4'b1100; b4 = 4'b1010; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
        xfer(1'b1, 3'd2, 1'b0, 1'b0, 4'h0);
        a4 = 4'b0101; b4 = 4'b0011; a32 = 32'hCAFE_F00D; b32 = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) xfer(1'b1, 3'd1, 1'b0, 1'b0, 4'h0);
        xfer(1'b1, 3'd1, 1'b1, 1'b1, 4'b0111);
        xfer(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 40; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom); d4 = 4'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); d1 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; c32 = $urandom; d32 = $urandom;
            xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'b0, 4'h0);
        end

        // Reset while a result is stalled
        xfer(1'b1, 3'd7, 1'b0, 1'b0, 4'h0);
        xfer(1'b0, 3'd0, 1'b0, 1'b0, 4'h0);
        do_reset(1'b0);
        xfer(1'b0, 3'd0, 1'b0, 1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
